// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-measurement blocks.
//   GATE_*      : GATE_SEL encodings (0=1 s, 1=100 ms, 2=10 ms, 3=1 ms)
//   DIV_*       : clock divisor for each gate length
//   gate_ticks  : gate length in CLK ticks for a given clock rate and gate select
//   state_t     : measurement FSM states
package freq_meas_pkg;

    localparam logic [1:0] GATE_1S    = 2'd0;
    localparam logic [1:0] GATE_100MS = 2'd1;
    localparam logic [1:0] GATE_10MS  = 2'd2;
    localparam logic [1:0] GATE_1MS   = 2'd3;

    localparam int unsigned DIV_1S    = 1;
    localparam int unsigned DIV_100MS = 10;
    localparam int unsigned DIV_10MS  = 100;
    localparam int unsigned DIV_1MS   = 1000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Each branch divides constants only, so this folds to a 4-way mux.
    function automatic int unsigned gate_ticks(input int unsigned clk_hz,
                                               input logic [1:0]  sel);
        int unsigned t;
        case (sel)
            GATE_1S:    t = clk_hz / DIV_1S;
            GATE_100MS: t = clk_hz / DIV_100MS;
            GATE_10MS:  t = clk_hz / DIV_10MS;
            default:    t = clk_hz / DIV_1MS;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/freq_edge_channel.sv
// One measurement channel: input synchroniser, rising-edge detector,
// saturating edge counter and the published FREQ/OVF register.
//   CLK, RST  : clock, synchronous active-high reset
//   din       : asynchronous input
//   clr       : discard the partial window (counter and overflow flag to 0)
//   boundary  : last cycle of a window; publish count including this cycle's edge
//   hold      : counter frozen (FSM idle)
//   freq, ovf : published count and saturation flag of the last completed window
module freq_edge_channel #(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             din,
    input  logic             clr,
    input  logic             boundary,
    input  logic             hold,
    output logic [CNT_W-1:0] freq,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sat_q;
    logic                   edge_det;
    logic                   add_sat;
    logic [CNT_W-1:0]       cnt_next;

    // cnt_next already includes this cycle's edge so a boundary edge lands
    // in the closing window rather than being dropped.
    always_comb begin
        edge_det = sync_q[SYNC_STAGES-1] & ~last_q;
        add_sat  = edge_det && (cnt_q == CNT_MAX);
        cnt_next = cnt_q;
        if (edge_det && !add_sat) begin
            cnt_next = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
            freq   <= '0;
            ovf    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
            if (boundary) begin
                freq  <= cnt_next;
                ovf   <= sat_q | add_sat;
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (clr) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (!hold) begin
                cnt_q <= cnt_next;
                sat_q <= sat_q | add_sat;
            end
        end
    end

endmodule

// File: rtl/freq_counter_multi.sv
// N-channel frequency counter: counts rising edges on each input over a
// common gate window (1 s / 100 ms / 10 ms / 1 ms) and publishes one count
// per channel per window.
//   CLK       : system clock
//   RST       : synchronous reset, active-high
//   EN        : measurement enable; dropping it discards the partial window
//   GATE_SEL  : gate select, latched at window start / boundary only
//   IN        : asynchronous inputs, one per channel
//   FREQ      : per-channel edge counts, channel k at [k*CNT_W +: CNT_W]
//   OVF       : per-channel saturation flag for the published window
//   VALID     : one-cycle pulse when FREQ/OVF update
//   GATE_ACT  : gate select that produced the published FREQ
module freq_counter_multi
    import freq_meas_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [1:0]            GATE_SEL,
    input  logic [N_CH-1:0]       IN,
    output logic [N_CH*CNT_W-1:0] FREQ,
    output logic [N_CH-1:0]       OVF,
    output logic                  VALID,
    output logic [1:0]            GATE_ACT
);

    localparam int unsigned TW = $clog2(CLK_HZ);

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] gt_last;
    logic [1:0]    gate_q;
    logic          boundary;
    logic          clr;
    logic          hold;

    always_comb begin
        gt_last  = TW'(gate_ticks(CLK_HZ, gate_q) - 1);
        boundary = (state_q == MEASURE) && EN && (timer_q == gt_last);
        clr      = (state_q == MEASURE) && !EN;
        hold     = (state_q == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            gate_q   <= GATE_SEL;
            GATE_ACT <= '0;
            VALID    <= 1'b0;
        end else begin
            VALID <= boundary;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (EN) begin
                        gate_q  <= GATE_SEL;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (!EN) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                    end else if (boundary) begin
                        timer_q  <= '0;
                        GATE_ACT <= gate_q;
                        gate_q   <= GATE_SEL;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        freq_edge_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .din      (IN[k]),
            .clr      (clr),
            .boundary (boundary),
            .hold     (hold),
            .freq     (FREQ[k*CNT_W +: CNT_W]),
            .ovf      (OVF[k])
        );
    end

endmodule

// File: tb/tb_freq_counter_multi.sv
// Bench for freq_counter_multi with CLK_HZ=10000 (gates of 10000/1000/100/10
// ticks) and CNT_W=8. A reference model tracks input levels and window
// boundaries and pushes the expected result of every window into a queue that
// a monitor drains on each VALID pulse.
module tb_freq_counter_multi;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned CLK_HZ      = 10000;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned MAXC        = (1 << CNT_W) - 1;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  EN  = 1'b0;
    logic [1:0]            GATE_SEL = 2'd3;
    logic [N_CH-1:0]       IN  = '0;
    logic [N_CH*CNT_W-1:0] FREQ;
    logic [N_CH-1:0]       OVF;
    logic                  VALID;
    logic [1:0]            GATE_ACT;

    freq_counter_multi #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .CLK_HZ      (CLK_HZ),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .GATE_SEL (GATE_SEL),
        .IN       (IN),
        .FREQ     (FREQ),
        .OVF      (OVF),
        .VALID    (VALID),
        .GATE_ACT (GATE_ACT)
    );

    always #5 CLK = ~CLK;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          mon_on = 1'b0;

    typedef struct packed {
        logic [N_CH*CNT_W-1:0] freq;
        logic [N_CH-1:0]       ovf;
        logic [1:0]            gate;
    } exp_t;
    exp_t sb[$];

    function automatic int unsigned gt(input logic [1:0] sel);
        int unsigned div = 1;
        for (int unsigned i = 0; i < sel; i++) div = div * 10;
        return CLK_HZ / div;
    endfunction

    // ---------------- input waveform driver ----------------
    // per[k]: 0 = static level fixv[k], 1 = random bit per cycle, >=2 = square wave period
    int unsigned     per[N_CH];
    logic [N_CH-1:0] fixv = '0;
    int unsigned     drv_cyc = 0;

    initial for (int k = 0; k < N_CH; k++) per[k] = 0;

    always @(posedge CLK) begin
        #2;
        drv_cyc++;
        for (int k = 0; k < N_CH; k++) begin
            if (per[k] == 0)      IN[k] = fixv[k];
            else if (per[k] == 1) IN[k] = 1'($urandom_range(0, 1));
            else                  IN[k] = ((drv_cyc % per[k]) < (per[k] / 2));
        end
    end

    // ---------------- reference model ----------------
    // An input level first sampled at posedge n is seen as an edge at posedge n+2.
    logic [N_CH-1:0]       m_h1 = '0, m_h2 = '0, m_h3 = '0;
    int unsigned           m_cnt[N_CH];
    int unsigned           m_ticks = 0;
    int unsigned           m_cyc = 0;
    bit                    m_meas = 1'b0;
    logic [1:0]            m_gate = 2'd0;
    logic [N_CH*CNT_W-1:0] m_pub_freq = '0;
    logic [N_CH-1:0]       m_pub_ovf = '0;
    logic [1:0]            m_pub_gate = '0;

    always @(posedge CLK) begin
        logic [N_CH-1:0] e;
        exp_t            x;
        e    = m_h2 & ~m_h3;
        m_h3 = m_h2;
        m_h2 = m_h1;
        m_h1 = IN;
        m_cyc++;
        if (RST) begin
            m_h1 = '0; m_h2 = '0; m_h3 = '0;
            m_meas = 1'b0; m_ticks = 0; m_gate = GATE_SEL;
            for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
            m_pub_freq = '0; m_pub_ovf = '0; m_pub_gate = '0;
        end else if (!m_meas) begin
            if (EN) begin
                m_meas = 1'b1; m_ticks = 0; m_gate = GATE_SEL;
                for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
            end
        end else if (!EN) begin
            m_meas = 1'b0; m_ticks = 0;
            for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
        end else begin
            for (int k = 0; k < N_CH; k++) m_cnt[k] += int'(e[k]);
            m_ticks++;
            if (m_ticks == gt(m_gate)) begin
                for (int k = 0; k < N_CH; k++) begin
                    x.freq[k*CNT_W +: CNT_W] = CNT_W'((m_cnt[k] > MAXC) ? MAXC : m_cnt[k]);
                    x.ovf[k] = (m_cnt[k] > MAXC);
                    m_cnt[k] = 0;
                end
                x.gate = m_gate;
                sb.push_back(x);
                m_pub_freq = x.freq; m_pub_ovf = x.ovf; m_pub_gate = x.gate;
                m_ticks = 0;
                m_gate = GATE_SEL;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic monitor_loop();
        exp_t x;
        forever begin
            @(negedge CLK);
            if (mon_on) begin
                if (VALID) begin
                    if (sb.size() == 0) begin
                        chk("valid_unexpected", 1, 0);
                    end else begin
                        x = sb.pop_front();
                        chk("valid_freq", longint'(FREQ), longint'(x.freq));
                        chk("valid_ovf", longint'(OVF), longint'(x.ovf));
                        chk("valid_gate_act", longint'(GATE_ACT), longint'(x.gate));
                    end
                end else if (sb.size() != 0) begin
                    chk("valid_missing", 0, 1);
                    sb.delete();
                end
                chk("held_freq", longint'(FREQ), longint'(m_pub_freq));
                chk("held_ovf_gate", longint'({OVF, GATE_ACT}), longint'({m_pub_ovf, m_pub_gate}));
            end
        end
    endtask

    function automatic int unsigned fch(input int k);
        return int'(FREQ[k*CNT_W +: CNT_W]);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input int unsigned limit);
        int unsigned n = 0;
        do begin
            step();
            n++;
        end while (!VALID && n < limit);
        chk("wait_valid_timeout", longint'(VALID), 1);
    endtask

    // Returns right after the posedge that leaves the model at the given tick.
    task automatic wait_tick(input int unsigned target, input int unsigned limit);
        int unsigned n = 0;
        while (!(m_meas && m_ticks == target) && n < limit) begin
            step();
            n++;
        end
        chk("wait_tick_timeout", longint'(m_meas && m_ticks == target), 1);
    endtask

    initial begin
        int unsigned c0;
        int unsigned f;
        fork
            monitor_loop();
        join_none

        repeat (3) step();
        chk("reset_freq", longint'(FREQ), 0);
        chk("reset_ovf", longint'(OVF), 0);
        chk("reset_valid", longint'(VALID), 0);
        chk("reset_gate_act", longint'(GATE_ACT), 0);
        RST = 1'b0;
        mon_on = 1'b1;
        repeat (4) step();

        // 1 ms gate, period-4 wave on channel 0
        c0 = m_cyc;
        EN = 1'b1; GATE_SEL = 2'd3; per[0] = 4;
        wait_valid(50);
        chk("first_valid_latency", longint'(m_cyc - c0), 11);
        f = fch(0);
        chk("first_freq0_2or3", longint'(f == 2 || f == 3), 1);
        chk("first_gate_act", longint'(GATE_ACT), 3);
        for (int i = 0; i < 4; i++) begin
            wait_valid(20);
            f = fch(0);
            chk("p4_freq0_2or3", longint'(f == 2 || f == 3), 1);
        end
        per[0] = 2;
        wait_valid(20);
        for (int i = 0; i < 2; i++) begin
            wait_valid(20);
            chk("p2_freq0", longint'(fch(0)), 5);
        end

        // 10 ms gate, single pulse on channel 1 landing on the boundary cycle
        GATE_SEL = 2'd2;
        wait_valid(20);
        wait_tick(gt(2) - 3, 300);
        fixv[1] = 1'b1;
        wait_valid(20);
        fixv[1] = 1'b0;
        chk("pulse_boundary_freq1", longint'(fch(1)), 1);
        chk("pulse_gate_act", longint'(GATE_ACT), 2);
        wait_valid(300);
        chk("pulse_next_freq1", longint'(fch(1)), 0);

        // saturation on channel 2 with a 1000-tick gate
        per[2] = 2;
        GATE_SEL = 2'd1;
        wait_valid(300);
        wait_valid(1200);
        chk("sat_freq2", longint'(fch(2)), MAXC);
        chk("sat_ovf2", longint'(OVF[2]), 1);
        per[2] = 200;
        wait_valid(1200);
        chk("slow_ovf2", longint'(OVF[2]), 0);

        // gate change mid-window: 3 -> 0, then back to 3 mid 1 s window
        GATE_SEL = 2'd3;
        wait_valid(1200);
        wait_tick(4, 50);
        GATE_SEL = 2'd0;
        wait_valid(20);
        chk("midchange_gate_act_old", longint'(GATE_ACT), 3);
        c0 = m_cyc;
        GATE_SEL = 2'd3;
        wait_valid(10100);
        chk("long_window_len", longint'(m_cyc - c0), 10000);
        chk("long_gate_act", longint'(GATE_ACT), 0);
        wait_valid(20);
        chk("after_long_gate_act", longint'(GATE_ACT), 3);

        // EN dropped at timer 5: window discarded, then a fresh full window
        wait_tick(5, 50);
        EN = 1'b0;
        repeat (15) step();
        c0 = m_cyc;
        EN = 1'b1;
        wait_valid(50);
        chk("reen_latency", longint'(m_cyc - c0), 11);

        // randomized phase
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < N_CH; k++) begin
                per[k]  = $urandom_range(0, 9);
                fixv[k] = 1'($urandom_range(0, 1));
            end
            GATE_SEL = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 30)) step();
                EN = 1'b0;
                repeat ($urandom_range(1, 4)) step();
                EN = 1'b1;
            end
            wait_valid(2500);
        end

        // reset on the boundary cycle
        GATE_SEL = 2'd3;
        wait_valid(1200);
        wait_tick(gt(m_gate) - 1, 50);
        RST = 1'b1;
        step();
        RST = 1'b0;
        EN  = 1'b0;
        chk("rstb_valid", longint'(VALID), 0);
        chk("rstb_freq", longint'(FREQ), 0);
        chk("rstb_ovf", longint'(OVF), 0);
        chk("rstb_gate_act", longint'(GATE_ACT), 0);
        repeat (25) step();
        chk("rstb_idle_no_valid", longint'(VALID), 0);
        c0 = m_cyc;
        EN = 1'b1;
        wait_valid(50);
        chk("rstb_restart_latency", longint'(m_cyc - c0), 11);
        EN = 1'b0;
        repeat (5) step();
        chk("scoreboard_drained", longint'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
